sram_req_sync: RTL and testbench

//  Parametrised successor to the per-bit SRAM input synchronizer. Moves one SRAM request

---
 rtl/sram_req_sync_if.sv | 29 ++
 rtl/sram_req_sync.sv | 137 +++++++++++++
 tb/tb_sram_req_sync.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_sync_if.sv
`default_nettype none
// ============================================================================
//  Module : sram_req_sync_if
//  Brief  : Captured SRAM request bundle plus its valid/ready handshake.
//  Rev    : 1.0  initial release
// ============================================================================
interface sram_req_sync_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int CONF_W = 2
);
    logic [DATA_W-1:0] D_in_sync;
    logic [ADDR_W-1:0] addr_sync;
    logic [CONF_W-1:0] conf_sync;
    logic              web_sync;
    logic              req_valid;
    logic              req_ready;

    modport master (
        output D_in_sync, addr_sync, conf_sync, web_sync, req_valid,
        input  req_ready
    );

    modport slave (
        input  D_in_sync, addr_sync, conf_sync, web_sync, req_valid,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/sram_req_sync.sv
`default_nettype none
// ============================================================================
//  Module : sram_req_sync
//  Brief  : Moves one csb-framed SRAM request bundle into the sram_clk domain.
//  Rev    : 1.0  initial release
// ============================================================================
module sram_req_sync #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 12,
    parameter int CONF_W        = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  wire logic              sram_clk,
    input  wire logic              sram_rst_n,
    input  wire logic [DATA_W-1:0] D_in,
    input  wire logic [ADDR_W-1:0] addr,
    input  wire logic [CONF_W-1:0] conf,
    input  wire logic              web,
    input  wire logic              csb,
    output      logic              busy,
    output      logic              drop_err,
    input  wire logic              clr_err,
    sram_req_sync_if.master        req
);
    localparam int c_BUN_W = DATA_W + ADDR_W + CONF_W + 1;
    localparam int c_CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_CYCLES - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SETTLE  = 2'd1;
    localparam logic [1:0] c_PEND    = 2'd2;
    localparam logic [1:0] c_WAIT_HI = 2'd3;

    logic [SYNC_STAGES-1:0] r_csb_sync;
    logic                   r_csb_s_d;
    logic [c_BUN_W-1:0]     r_bun_q;
    logic [c_BUN_W-1:0]     r_shadow;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [1:0]             r_state;
    logic [DATA_W-1:0]      r_d_sync;
    logic [ADDR_W-1:0]      r_addr_sync;
    logic [CONF_W-1:0]      r_conf_sync;
    logic                   r_web_sync;
    logic                   r_req_valid;
    logic                   r_drop_err;

    logic                   w_csb_s;
    logic                   w_fall;
    logic [c_BUN_W-1:0]     w_bun_in;

    assign w_csb_s  = r_csb_sync[SYNC_STAGES-1];
    assign w_fall   = ~w_csb_s & r_csb_s_d;
    assign w_bun_in = {D_in, addr, conf, web};

    // Only csb is synchronised; the bundle is trusted once it has held steady.
    always_ff @(posedge sram_clk or negedge sram_rst_n) begin
        if (!sram_rst_n) begin
            r_csb_sync <= '1;
        end else begin
            r_csb_sync <= {r_csb_sync[SYNC_STAGES-2:0], csb};
        end
    end

    always_ff @(posedge sram_clk or negedge sram_rst_n) begin
        if (!sram_rst_n) begin
            r_csb_s_d   <= 1'b1;
            r_bun_q     <= '0;
            r_shadow    <= '0;
            r_cnt       <= '0;
            r_state     <= c_IDLE;
            r_d_sync    <= '0;
            r_addr_sync <= '0;
            r_conf_sync <= '0;
            r_web_sync  <= 1'b0;
            r_req_valid <= 1'b0;
            r_drop_err  <= 1'b0;
        end else begin
            r_csb_s_d <= w_csb_s;
            r_bun_q   <= w_bun_in;

            // A new request while one is still pending is lost; set beats clear.
            if (w_fall && (r_state == c_PEND)) begin
                r_drop_err <= 1'b1;
            end else if (clr_err) begin
                r_drop_err <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_fall) begin
                        r_shadow <= r_bun_q;
                        r_cnt    <= '0;
                        r_state  <= c_SETTLE;
                    end
                end
                c_SETTLE: begin
                    if (w_csb_s) begin
                        r_state <= c_IDLE;
                    end else if (r_bun_q == r_shadow) begin
                        if (r_cnt == c_CNT_LAST) begin
                            {r_d_sync, r_addr_sync, r_conf_sync, r_web_sync} <= r_shadow;
                            r_req_valid <= 1'b1;
                            r_state     <= c_PEND;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end else begin
                        r_shadow <= r_bun_q;
                        r_cnt    <= '0;
                    end
                end
                c_PEND: begin
                    if (req.req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= w_csb_s ? c_IDLE : c_WAIT_HI;
                    end
                end
                c_WAIT_HI: begin
                    if (w_csb_s) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy          = (r_state != c_IDLE);
    assign drop_err      = r_drop_err;
    assign req.D_in_sync = r_d_sync;
    assign req.addr_sync = r_addr_sync;
    assign req.conf_sync = r_conf_sync;
    assign req.web_sync  = r_web_sync;
    assign req.req_valid = r_req_valid;
endmodule
`default_nettype wire

// File: tb/tb_sram_req_sync.sv
`default_nettype none
// ============================================================================
//  Module : tb_sram_req_sync
//  Brief  : Directed, table-driven self-checking bench for sram_req_sync.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_sram_req_sync;
    logic        sram_clk = 1'b0;
    logic        sram_rst_n;
    logic [31:0] D_in;
    logic [11:0] addr;
    logic [1:0]  conf;
    logic        web;
    logic        csb;
    logic        busy;
    logic        drop_err;
    logic        clr_err;

    int n_pass  = 0;
    int n_total = 0;

    sram_req_sync_if #(.DATA_W(32), .ADDR_W(12), .CONF_W(2)) req_if ();

    sram_req_sync #(
        .DATA_W(32), .ADDR_W(12), .CONF_W(2), .SYNC_STAGES(2), .STABLE_CYCLES(2)
    ) dut (
        .sram_clk  (sram_clk),
        .sram_rst_n(sram_rst_n),
        .D_in      (D_in),
        .addr      (addr),
        .conf      (conf),
        .web       (web),
        .csb       (csb),
        .busy      (busy),
        .drop_err  (drop_err),
        .clr_err   (clr_err),
        .req       (req_if)
    );

    always #5 sram_clk = ~sram_clk;

    typedef struct {
        logic        csb;
        logic [11:0] addr;
        logic [31:0] d;
        logic        exp_valid;
        logic        exp_busy;
        logic [11:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic c, input logic [11:0] a, input logic [31:0] d,
                        input logic ev, input logic eb, input logic [11:0] ea);
        vec_t v;
        v.csb = c; v.addr = a; v.d = d;
        v.exp_valid = ev; v.exp_busy = eb; v.exp_addr = ea;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge sram_clk);
        #1;
    endtask

    int pulses;

    initial begin
        sram_rst_n = 1'b0;
        D_in = 32'hDEADBEEF; addr = 12'h0A5; conf = 2'd0; web = 1'b0;
        csb = 1'b1; clr_err = 1'b0; req_if.req_ready = 1'b1;

        // Test 1: clean request, valid after edge 5 for one cycle
        for (int i = 1; i <= 4; i++) addv(1'b0, 12'h0A5, 32'hDEADBEEF, 1'b0, i >= 3, 12'h000);
        addv(1'b0, 12'h0A5, 32'hDEADBEEF, 1'b1, 1'b1, 12'h0A5);
        for (int i = 6; i <= 10; i++) addv(1'b0, 12'h0A5, 32'hDEADBEEF, 1'b0, 1'b1, 12'h0A5);
        addv(1'b1, 12'h0A5, 32'hDEADBEEF, 1'b0, 1'b1, 12'h0A5);
        addv(1'b1, 12'h0A5, 32'hDEADBEEF, 1'b0, 1'b1, 12'h0A5);
        addv(1'b1, 12'h0A5, 32'hDEADBEEF, 1'b0, 1'b0, 12'h0A5);
        // Test 2: addr changes as SETTLE begins -> one mismatch, valid one edge later
        addv(1'b0, 12'h001, 32'h12345678, 1'b0, 1'b0, 12'h0A5);
        addv(1'b0, 12'h001, 32'h12345678, 1'b0, 1'b0, 12'h0A5);
        for (int i = 3; i <= 5; i++) addv(1'b0, 12'h002, 32'h12345678, 1'b0, 1'b1, 12'h0A5);
        addv(1'b0, 12'h002, 32'h12345678, 1'b1, 1'b1, 12'h002);
        addv(1'b0, 12'h002, 32'h12345678, 1'b0, 1'b1, 12'h002);
        addv(1'b1, 12'h002, 32'h12345678, 1'b0, 1'b1, 12'h002);
        addv(1'b1, 12'h002, 32'h12345678, 1'b0, 1'b1, 12'h002);
        addv(1'b1, 12'h002, 32'h12345678, 1'b0, 1'b0, 12'h002);
        // Test 3: two-cycle csb pulse aborts in SETTLE
        addv(1'b0, 12'h002, 32'h12345678, 1'b0, 1'b0, 12'h002);
        addv(1'b0, 12'h002, 32'h12345678, 1'b0, 1'b0, 12'h002);
        addv(1'b1, 12'h002, 32'h12345678, 1'b0, 1'b1, 12'h002);
        addv(1'b1, 12'h002, 32'h12345678, 1'b0, 1'b1, 12'h002);
        for (int i = 5; i <= 7; i++) addv(1'b1, 12'h002, 32'h12345678, 1'b0, 1'b0, 12'h002);

        step(3);
        chk("reset_valid", {31'd0, req_if.req_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_drop", {31'd0, drop_err}, 32'd0);
        chk("reset_dsync", req_if.D_in_sync, 32'd0);
        chk("reset_addr", {20'd0, req_if.addr_sync}, 32'd0);
        sram_rst_n = 1'b1;
        step(3);

        for (int i = 0; i < vecs.size(); i++) begin
            csb = vecs[i].csb; addr = vecs[i].addr; D_in = vecs[i].d;
            step(1);
            chk($sformatf("vec%0d_valid", i), {31'd0, req_if.req_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            chk($sformatf("vec%0d_addr", i), {20'd0, req_if.addr_sync}, {20'd0, vecs[i].exp_addr});
            chk($sformatf("vec%0d_drop", i), {31'd0, drop_err}, 32'd0);
            if (i == 12) chk("t1_dsync", req_if.D_in_sync, 32'hDEADBEEF);
            if (i == 12) chk("t1_web", {31'd0, req_if.web_sync}, 32'd0);
        end
        chk("t2_dsync", req_if.D_in_sync, 32'h12345678);

        // Test 4: held request, dropped second request, clear and set/clear race
        req_if.req_ready = 1'b0; addr = 12'h111; D_in = 32'h11111111; web = 1'b1; conf = 2'd2;
        step(2);
        csb = 1'b0; step(5);
        chk("t4_valid", {31'd0, req_if.req_valid}, 32'd1);
        chk("t4_addr", {20'd0, req_if.addr_sync}, 32'h111);
        chk("t4_conf", {30'd0, req_if.conf_sync}, 32'd2);
        csb = 1'b1; step(3);
        addr = 12'h222; D_in = 32'h22222222;
        csb = 1'b0; step(2);
        chk("t4_drop_early", {31'd0, drop_err}, 32'd0);
        step(1);
        chk("t4_drop_set", {31'd0, drop_err}, 32'd1);
        chk("t4_held_valid", {31'd0, req_if.req_valid}, 32'd1);
        chk("t4_held_addr", {20'd0, req_if.addr_sync}, 32'h111);
        chk("t4_held_d", req_if.D_in_sync, 32'h11111111);
        csb = 1'b1; step(3);
        clr_err = 1'b1; step(1); clr_err = 1'b0;
        chk("t4_drop_clr", {31'd0, drop_err}, 32'd0);
        csb = 1'b0; step(2);
        clr_err = 1'b1; step(1); clr_err = 1'b0;
        chk("t4_set_wins", {31'd0, drop_err}, 32'd1);
        req_if.req_ready = 1'b1; step(1);
        chk("t4_accept", {31'd0, req_if.req_valid}, 32'd0);
        chk("t4_addr_kept", {20'd0, req_if.addr_sync}, 32'h111);
        csb = 1'b1; step(3);
        chk("t4_idle", {31'd0, busy}, 32'd0);
        clr_err = 1'b1; step(1); clr_err = 1'b0;
        chk("t4_drop_clr2", {31'd0, drop_err}, 32'd0);

        // Test 5: csb held low for 50 cycles yields a single request
        addr = 12'h155; D_in = 32'hA5A5A5A5; web = 1'b0; conf = 2'd1;
        step(2);
        pulses = 0;
        csb = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (req_if.req_valid) pulses++;
        end
        csb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (req_if.req_valid) pulses++;
        end
        chk("t5_pulses", pulses, 32'd1);
        chk("t5_addr", {20'd0, req_if.addr_sync}, 32'h155);
        chk("t5_idle", {31'd0, busy}, 32'd0);

        // Test 6: reset while PEND clears everything without a clock edge
        req_if.req_ready = 1'b0; addr = 12'h2AA; D_in = 32'h55AA55AA;
        step(2);
        csb = 1'b0; step(5);
        chk("t6_valid", {31'd0, req_if.req_valid}, 32'd1);
        csb = 1'b1; step(3);
        csb = 1'b0; step(3);
        chk("t6_drop", {31'd0, drop_err}, 32'd1);
        #1 sram_rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, req_if.req_valid}, 32'd0);
        chk("t6_rst_addr", {20'd0, req_if.addr_sync}, 32'd0);
        chk("t6_rst_d", req_if.D_in_sync, 32'd0);
        chk("t6_rst_drop", {31'd0, drop_err}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        csb = 1'b1; step(2);
        sram_rst_n = 1'b1;
        req_if.req_ready = 1'b1; addr = 12'h3C3; D_in = 32'hCAFEF00D;
        step(2);
        csb = 1'b0; step(4);
        chk("t6_not_yet", {31'd0, req_if.req_valid}, 32'd0);
        step(1);
        chk("t6_valid2", {31'd0, req_if.req_valid}, 32'd1);
        chk("t6_addr2", {20'd0, req_if.addr_sync}, 32'h3C3);
        chk("t6_d2", req_if.D_in_sync, 32'hCAFEF00D);
        step(1);
        chk("t6_done", {31'd0, req_if.req_valid}, 32'd0);
        csb = 1'b1; step(3);
        chk("t6_idle", {31'd0, busy}, 32'd0);
        chk("t6_no_drop", {31'd0, drop_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
